fp_norm_pack: RTL

//  Post-adder stage of the FP adder. It takes the signed-magnitude mantissa
//  sum, the result sign and the exponent, then normalises, rounds and packs

---
 rtl/fp_norm_pack_if.sv | 27 ++
 rtl/fp_norm_pack.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fp_norm_pack_if.sv
// Handshake and data bundle between the FP adder datapath and the normalise/round/pack stage.
interface fp_norm_pack_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W-1:0]       in_exp;
  logic [MAN_W+4:0]       in_mant;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   result;
  logic                   ovf;
  logic                   uf;
  logic                   zero;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, result, ovf, uf, zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, result, ovf, uf, zero
  );
endinterface

// File: rtl/fp_norm_pack.sv
// Normalise (one shift per cycle), round-to-nearest-even and pack an FP sum; FP_FTZ_EN flushes denormals.
// Latency 2+k cycles (k left shifts), 1 for zero/inf; one op in flight, result held until out_ready.
module fp_norm_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            rst,
  fp_norm_pack_if.slave   bus
);
  localparam int MW = MAN_W + 5;
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t               state_q, state_n;
  logic                 sign_q, sign_n;
  logic [EXP_W:0]       exp_q, exp_n;
  logic [MW-1:0]        mant_q, mant_n;
  logic                 zin_q, zin_n;
  logic                 inf_q, inf_n;
  logic [EXP_W+MAN_W:0] result_q, result_n;
  logic                 ovf_q, ovf_n;
  logic                 uf_q, uf_n;
  logic                 zero_q, zero_n;

  logic                 g, r, s, l, up, tiny, inexact, hid_r;
  logic [MAN_W+1:0]     sum;
  logic [MAN_W-1:0]     frac_r;
  logic [EXP_W:0]       exp_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      zin_q    <= 1'b0;
      inf_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      uf_q     <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      sign_q   <= sign_n;
      exp_q    <= exp_n;
      mant_q   <= mant_n;
      zin_q    <= zin_n;
      inf_q    <= inf_n;
      result_q <= result_n;
      ovf_q    <= ovf_n;
      uf_q     <= uf_n;
      zero_q   <= zero_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    sign_n   = sign_q;
    exp_n    = exp_q;
    mant_n   = mant_q;
    zin_n    = zin_q;
    inf_n    = inf_q;
    result_n = result_q;
    ovf_n    = ovf_q;
    uf_n     = uf_q;
    zero_n   = zero_q;

    // Rounding datapath, only consumed in ROUND
    l       = mant_q[3];
    g       = mant_q[2];
    r       = mant_q[1];
    s       = mant_q[0];
    up      = g & (l | r | s);
    inexact = g | r | s;
    tiny    = ~mant_q[MW-2];
    sum     = {1'b0, mant_q[MW-2:3]} + {{(MAN_W+1){1'b0}}, up};
    if (sum[MAN_W+1]) begin
      frac_r = sum[MAN_W:1];
      hid_r  = 1'b1;
      exp_r  = exp_q + EXP_ONE;
    end else begin
      frac_r = sum[MAN_W-1:0];
      hid_r  = sum[MAN_W];
      exp_r  = exp_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_n   = bus.in_sign;
          exp_n    = (bus.in_exp == '0) ? EXP_ONE : {1'b0, bus.in_exp};
          mant_n   = bus.in_mant;
          zin_n    = (bus.in_mant == '0);
          inf_n    = &bus.in_exp;
          result_n = '0;
          ovf_n    = 1'b0;
          uf_n     = 1'b0;
          zero_n   = 1'b0;
          state_n  = NORM;
        end
      end
      NORM: begin
        if (zin_q) begin
          result_n = '0;
          zero_n   = 1'b1;
          state_n  = DONE;
        end else if (inf_q) begin
          result_n = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_n    = 1'b1;
          state_n  = DONE;
        end else if (mant_q[MW-1]) begin
          // Keep the dropped bit sticky so rounding still sees inexactness
          mant_n  = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
          exp_n   = exp_q + EXP_ONE;
          state_n = ROUND;
        end else if (mant_q[MW-2] || exp_q == EXP_ONE) begin
          state_n = ROUND;
        end else begin
          mant_n = mant_q << 1;
          exp_n  = exp_q - EXP_ONE;
        end
      end
      ROUND: begin
        state_n = DONE;
        if (exp_r >= EXP_MAX) begin
          result_n = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_n    = 1'b1;
        end else if (!hid_r) begin
`ifdef FP_FTZ_EN
          result_n = {sign_q, {(EXP_W+MAN_W){1'b0}}};
          uf_n     = 1'b1;
          zero_n   = 1'b1;
`else
          result_n = {sign_q, {EXP_W{1'b0}}, frac_r};
          uf_n     = inexact;
          zero_n   = (frac_r == '0);
`endif
        end else begin
          // A denormal rounded up into the hidden bit lands here with exp 1
          result_n = {sign_q, exp_r[EXP_W-1:0], frac_r};
          uf_n     = tiny & inexact;
        end
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.uf        = uf_q;
  assign bus.zero      = zero_q;
endmodule
